// File: rtl/n_bit_4x1_multiplexer.sv
// Purpose    : n-bit 4:1 selector (A/B/C/D by S) feeding an enable-gated output register.
// Latency    : 1 clk; inputs sampled on an enabled edge appear on Y right after that edge.
// Backpressure: none; every enabled edge captures, Y_valid flags exactly those cycles.
//
// Ports:
//   clk      - single clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset, clears Y and Y_valid immediately
//   A,B,C,D  - n-bit data inputs, selected by S = 00/01/10/11
//   S        - 2-bit select code
//   en       - capture enable for the output register
//   Y        - registered selector output, holds its value while en=0
//   Y_valid  - high for the cycle after each enabled edge
module n_bit_4x1_multiplexer #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic [n-1:0] C,
    input  logic [n-1:0] D,
    input  logic [1:0]   S,
    input  logic         en,
    output logic [n-1:0] Y,
    output logic         Y_valid
);

    logic [n-1:0] sel;
    logic [n-1:0] y_d;
    logic [n-1:0] y_q;
    logic         vld_d;
    logic         vld_q;

    // Fully decoded selector. The default arm is reachable only when S
    // carries X/Z in simulation, where propagating X is the honest answer.
    always_comb begin
        sel = '0;
        case (S)
            2'b00:   sel = A;
            2'b01:   sel = B;
            2'b10:   sel = C;
            2'b11:   sel = D;
            default: sel = 'x;
        endcase
    end

    // Data holds while disabled; valid is simply the registered enable.
    always_comb begin
        y_d   = en ? sel : y_q;
        vld_d = en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            vld_q <= vld_d;
        end
    end

    assign Y       = y_q;
    assign Y_valid = vld_q;

endmodule

// File: tb/tb_n_bit_4x1_multiplexer.sv
// Purpose    : scoreboard bench for n_bit_4x1_multiplexer at widths 8, 1 and 32.
// Latency    : expects each capture one edge after the inputs are presented.
// Backpressure: none; the monitor pops one expected entry per clock edge.
module tb_n_bit_4x1_multiplexer;

    localparam logic [7:0]  DA8  = 8'hAA;
    localparam logic [7:0]  DB8  = 8'h66;
    localparam logic [7:0]  DC8  = 8'hDD;
    localparam logic [7:0]  DD8  = 8'h11;
    localparam logic [31:0] DA32 = 32'hDEADBEEF;
    localparam logic [31:0] DB32 = 32'h01234567;
    localparam logic [31:0] DC32 = 32'h89ABCDEF;
    localparam logic [31:0] DD32 = 32'hCAFEF00D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s;
    logic        en;
    logic [7:0]  a8, b8, c8, d8;
    logic        a1, b1, c1, d1;
    logic [31:0] a32, b32, c32, d32;
    logic [7:0]  y8;
    logic        v8;
    logic        y1;
    logic        v1;
    logic [31:0] y32;
    logic        v32;

    always #5 clk = ~clk;

    n_bit_4x1_multiplexer #(.n(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .C(c8), .D(d8),
        .S(s), .en(en), .Y(y8), .Y_valid(v8)
    );
    n_bit_4x1_multiplexer #(.n(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .C(c1), .D(d1),
        .S(s), .en(en), .Y(y1), .Y_valid(v1)
    );
    n_bit_4x1_multiplexer #(.n(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .A(a32), .B(b32), .C(c32), .D(d32),
        .S(s), .en(en), .Y(y32), .Y_valid(v32)
    );

    typedef struct packed {
        logic [7:0]  y8;
        logic        v8;
        logic        y1;
        logic        v1;
        logic [31:0] y32;
        logic        v32;
    } exp_t;

    exp_t q[$];
    exp_t m;          // reference state: what the outputs should be now
    int   vectors     = 0;
    int   miscompares = 0;
    bit   skip_mid    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a 4-entry table indexed by the select code, captured when enabled.
    task automatic model_step();
        logic [7:0]  t8[4];
        logic        t1[4];
        logic [31:0] t32[4];
        int          idx;
        t8  = '{a8, b8, c8, d8};
        t1  = '{a1, b1, c1, d1};
        t32 = '{a32, b32, c32, d32};
        idx = int'(s);
        if (en) begin
            m.y8  = t8[idx];
            m.y1  = t1[idx];
            m.y32 = t32[idx];
        end
        m.v8  = en;
        m.v1  = en;
        m.v32 = en;
        q.push_back(m);
    endtask

    task automatic set_directed();
        a8 = DA8;  b8 = DB8;  c8 = DC8;  d8 = DD8;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0;
        a32 = DA32; b32 = DB32; c32 = DC32; d32 = DD32;
    endtask

    task automatic set_random();
        a8 = 8'($urandom);  b8 = 8'($urandom);  c8 = 8'($urandom);  d8 = 8'($urandom);
        a1 = 1'($urandom);  b1 = 1'($urandom);  c1 = 1'($urandom);  d1 = 1'($urandom);
        a32 = $urandom; b32 = $urandom; c32 = $urandom; d32 = $urandom;
    endtask

    // One clock: optional junk on the inputs right after the edge, then the
    // real inputs for the next edge are set mid-cycle and the model records them.
    task automatic cyc(input bit e, input logic [1:0] sel, input bit glitch, input bit rnd);
        @(posedge clk);
        #1;
        if (glitch) begin
            s   = 2'($urandom);
            en  = 1'($urandom);
            a8  = ~a8;
            a1  = ~a1;
            a32 = ~a32;
        end
        #4;
        if (rnd) set_random(); else set_directed();
        en = e;
        s  = sel;
        model_step();
    endtask

    // Mid-cycle reset pulse spanning one edge, then release with en=0 for one edge.
    task automatic rst_pulse();
        @(posedge clk);
        #5;
        m = '0;
        q.push_back(m);
        skip_mid = 1'b1;
        en = 1'b1;
        s  = 2'($urandom);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_y8",  32'(y8),  32'h0);
        chk("async_rst_v8",  32'(v8),  32'h0);
        chk("async_rst_y32", 32'(y32), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        skip_mid = 1'b0;
        #4;
        en = 1'b0;
        model_step();
    endtask

    // Monitor: checks the entry for the last edge shortly after it, and again
    // late in the cycle to prove nothing moved between edges.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("y8",  32'(y8),  32'(cur.y8));
                chk("v8",  32'(v8),  32'(cur.v8));
                chk("y1",  32'(y1),  32'(cur.y1));
                chk("v1",  32'(v1),  32'(cur.v1));
                chk("y32", y32,      cur.y32);
                chk("v32", 32'(v32), 32'(cur.v32));
                #6;
                if (!skip_mid) begin
                    chk("stable_y8",  32'(y8),  32'(cur.y8));
                    chk("stable_v8",  32'(v8),  32'(cur.v8));
                    chk("stable_y32", y32,      cur.y32);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        s     = 2'b01;
        set_directed();
        m = '0;
        #1;
        chk("rst_y8",  32'(y8),  32'h0);
        chk("rst_v8",  32'(v8),  32'h0);
        chk("rst_y1",  32'(y1),  32'h0);
        chk("rst_y32", y32,      32'h0);
        // Held in reset across edges with en=1: outputs must stay cleared.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s = 2'($urandom);
            chk("rst_hold_y8", 32'(y8), 32'h0);
            chk("rst_hold_v8", 32'(v8), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b0;
        #4;
        model_step();                       // first edge after release, en=0

        for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 1'b0, 1'b0);   // select sweep
        cyc(1'b1, 2'b10, 1'b0, 1'b0);                              // capture DD
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);   // hold
        cyc(1'b1, 2'b01, 1'b0, 1'b0);                              // Y becomes 66
        rst_pulse();
        cyc(1'b1, 2'b11, 1'b0, 1'b0);                              // resume with 11
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'(3 - i), 1'b1, 1'b0); // glitchy sweep
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 1'b0, 1'b0);
        rst_pulse();
        cyc(1'b0, 2'b11, 1'b0, 1'b0);
        cyc(1'b1, 2'b11, 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) rst_pulse();
            else cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom), 1'b1);
        end

        @(posedge clk);
        @(posedge clk);
        #3;
        chk("drain", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
